// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Branch target buffer with 2-bit saturating direction counters. Gives the
// fetch stage a predicted next PC in the same cycle as the fetch. Also takes
// resolved outcomes back from EX, flags mispredictions with the correct
// redirect PC, and keeps saturating performance counters.
//
// Parameters
//   ENTRIES  number of BTB entries (power of two, >= 2)
//   ADDR_W   PC width
//   CNT_W    performance counter width
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   if_pc           PC being fetched
//   pred_taken      lookup hit and the counter predicts taken
//   pred_next_pc    predicted target if pred_taken, else if_pc + 4
//   upd_valid       a resolved branch/jump is in EX this cycle
//   upd_pc          PC of the resolved instruction
//   upd_taken       actual outcome (1 for jumps)
//   upd_target      actual taken target
//   upd_pred_next   prediction that travelled down the pipe with the instr
//   mispredict      combinational mispredict flag
//   redirect_pc     actual next PC of the resolved instruction
//   branch_cnt      saturating count of updates
//   mispred_cnt     saturating count of mispredictions
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic [ADDR_W-1:0] upd_pred_next,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // Read views of the per-entry flops (driven from the generate loop).
  logic              valid_arr  [ENTRIES];
  logic [TAG_W-1:0]  tag_arr    [ENTRIES];
  logic [ADDR_W-1:0] target_arr [ENTRIES];
  logic [1:0]        ctr_arr    [ENTRIES];

  // ---------------------------------------------------------------------
  // Lookup: purely combinational from registered state, no update bypass.
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx       = if_pc[IDX_W+1:2];
  assign if_tag       = if_pc[ADDR_W-1:IDX_W+2];
  assign if_hit       = valid_arr[if_idx] && (tag_arr[if_idx] == if_tag);
  assign pred_taken   = if_hit && ctr_arr[if_idx][1];
  assign pred_next_pc = pred_taken ? target_arr[if_idx] : if_pc + ADDR_W'(4);

  // ---------------------------------------------------------------------
  // Resolve
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] actual_pc;

  assign actual_pc   = upd_taken ? upd_target : upd_pc + ADDR_W'(4);
  assign redirect_pc = actual_pc;
  assign mispredict  = upd_valid && (upd_pred_next != actual_pc);

  // ---------------------------------------------------------------------
  // Update: compute the new contents of the addressed entry once, then
  // each entry latches it when it is the one addressed.
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_ctr;
  logic [1:0]       ctr_next;
  logic             entry_write;

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign upd_hit = valid_arr[upd_idx] && (tag_arr[upd_idx] == upd_tag);
  assign upd_ctr = ctr_arr[upd_idx];

  // A not-taken miss leaves the BTB alone; every other update writes.
  assign entry_write = upd_valid && (upd_hit || upd_taken);

  always_comb begin
    ctr_next = upd_ctr;
    if (!upd_hit) begin
      ctr_next = 2'b10;                       // fresh allocation: weak-taken
    end else if (upd_taken) begin
      if (upd_ctr != 2'b11) ctr_next = upd_ctr + 2'b01;
    end else begin
      if (upd_ctr != 2'b00) ctr_next = upd_ctr - 2'b01;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic              valid_reg;
      logic [TAG_W-1:0]  tag_reg;
      logic [ADDR_W-1:0] target_reg;
      logic [1:0]        ctr_reg;
      logic              sel;

      assign sel = entry_write && (upd_idx == IDX_W'(gi));

      // tag/target carry no reset: they are ignored while valid is low.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          ctr_reg   <= 2'b00;
        end else if (sel) begin
          valid_reg <= 1'b1;
          tag_reg   <= upd_tag;                // unchanged value on a hit
          ctr_reg   <= ctr_next;
          if (upd_taken) target_reg <= upd_target;
        end
      end

      assign valid_arr[gi]  = valid_reg;
      assign tag_arr[gi]    = tag_reg;
      assign target_arr[gi] = target_reg;
      assign ctr_arr[gi]    = ctr_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Performance counters, saturating at all-ones.
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] branch_cnt_reg, branch_cnt_next;
  logic [CNT_W-1:0] mispred_cnt_reg, mispred_cnt_next;

  always_comb begin
    branch_cnt_next  = branch_cnt_reg;
    mispred_cnt_next = mispred_cnt_reg;
    if (upd_valid && (branch_cnt_reg != {CNT_W{1'b1}}))
      branch_cnt_next = branch_cnt_reg + CNT_W'(1);
    if (mispredict && (mispred_cnt_reg != {CNT_W{1'b1}}))
      mispred_cnt_next = mispred_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_reg  <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      branch_cnt_reg  <= branch_cnt_next;
      mispred_cnt_reg <= mispred_cnt_next;
    end
  end

  assign branch_cnt  = branch_cnt_reg;
  assign mispred_cnt = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed bench for branch_predictor (ENTRIES=64, ADDR_W=32, CNT_W=4).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 1 unit later, registered effects after the following edge.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] upd_pred_next;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  branch_cnt;
  logic [3:0]  mispred_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .ENTRIES(64),
    .ADDR_W (32),
    .CNT_W  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_pc        (if_pc),
    .pred_taken   (pred_taken),
    .pred_next_pc (pred_next_pc),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .upd_pred_next(upd_pred_next),
    .mispredict   (mispredict),
    .redirect_pc  (redirect_pc),
    .branch_cnt   (branch_cnt),
    .mispred_cnt  (mispred_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic [31:0] pn);
    upd_valid     = 1'b1;
    upd_pc        = pc;
    upd_taken     = tk;
    upd_target    = tgt;
    upd_pred_next = pn;
  endtask

  task automatic idle();
    upd_valid = 1'b0;
  endtask

  // lookup at pc and check both prediction outputs
  task automatic look(input string tag, input logic [31:0] pc,
                      input logic tk, input logic [31:0] nxt);
    if_pc = pc;
    #1;
    chk({tag, ".pred_taken"}, 32'(pred_taken), 32'(tk));
    chk({tag, ".pred_next_pc"}, pred_next_pc, nxt);
    $display("lookup %-12s pc=0x%08h taken=%0d next=0x%08h", tag, pc, pred_taken, pred_next_pc);
  endtask

  task automatic resolve(input string tag, input logic mp, input logic [31:0] rd);
    #1;
    chk({tag, ".mispredict"}, 32'(mispredict), 32'(mp));
    chk({tag, ".redirect_pc"}, redirect_pc, rd);
    $display("update %-12s pc=0x%08h taken=%0d mispredict=%0d redirect=0x%08h",
             tag, upd_pc, upd_taken, mispredict, redirect_pc);
  endtask

  task automatic cnts(input string tag, input int b, input int m);
    chk({tag, ".branch_cnt"}, 32'(branch_cnt), 32'(b));
    chk({tag, ".mispred_cnt"}, 32'(mispred_cnt), 32'(m));
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'h40;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_pred_next = '0;
    tick(); tick();
    rst = 1'b0;

    // 1. reset state
    look("reset", 32'h40, 1'b0, 32'h44);
    cnts("reset", 0, 0);
    chk("reset.idle_mispredict", 32'(mispredict), 32'd0);

    // 2. cold taken branch; same-cycle lookup still sees the empty entry
    upd(32'h40, 1'b1, 32'h100, 32'h44);
    resolve("cold", 1'b1, 32'h100);
    look("cold_same", 32'h40, 1'b0, 32'h44);
    tick(); idle();
    look("cold_after", 32'h40, 1'b1, 32'h100);
    cnts("cold", 1, 1);

    // 3. hysteresis: 10 -> 01 -> 00 -> 01 -> 10
    upd(32'h40, 1'b0, 32'h100, 32'h100);
    resolve("nt1", 1'b1, 32'h44);
    tick(); idle();
    look("nt1", 32'h40, 1'b0, 32'h44);
    cnts("nt1", 2, 2);

    upd(32'h40, 1'b0, 32'h100, 32'h44);
    resolve("nt2", 1'b0, 32'h44);
    tick(); idle();
    look("nt2", 32'h40, 1'b0, 32'h44);
    cnts("nt2", 3, 2);

    upd(32'h40, 1'b1, 32'h100, 32'h44);
    resolve("t1", 1'b1, 32'h100);
    tick(); idle();
    look("t1", 32'h40, 1'b0, 32'h44);
    cnts("t1", 4, 3);

    upd(32'h40, 1'b1, 32'h100, 32'h44);
    resolve("t2", 1'b1, 32'h100);
    tick(); idle();
    look("t2", 32'h40, 1'b1, 32'h100);
    cnts("t2", 5, 4);

    // taken hit with a new target replaces the stored target
    upd(32'h40, 1'b1, 32'h180, 32'h100);
    resolve("retarget", 1'b1, 32'h180);
    tick(); idle();
    look("retarget", 32'h40, 1'b1, 32'h180);
    cnts("retarget", 6, 5);

    // 4. alias eviction: 0x140 shares index 16 with 0x40
    upd(32'h140, 1'b1, 32'h200, 32'h144);
    resolve("alias", 1'b1, 32'h200);
    tick(); idle();
    look("alias_new", 32'h140, 1'b1, 32'h200);
    look("alias_old", 32'h40, 1'b0, 32'h44);
    cnts("alias", 7, 6);

    upd(32'h240, 1'b0, 32'h999, 32'h244);
    resolve("nt_miss", 1'b0, 32'h244);
    tick(); idle();
    look("nt_miss_keep", 32'h140, 1'b1, 32'h200);
    look("nt_miss_none", 32'h240, 1'b0, 32'h244);
    cnts("nt_miss", 8, 6);

    // freshly allocated counter is weak-taken: one not-taken drops it
    upd(32'h140, 1'b0, 32'h200, 32'h200);
    resolve("alloc_weak", 1'b1, 32'h144);
    tick(); idle();
    look("alloc_weak", 32'h140, 1'b0, 32'h144);
    cnts("alloc_weak", 9, 7);

    // 5a. same-cycle lookup and update: no bypass
    upd(32'h140, 1'b1, 32'h200, 32'h144);
    resolve("same", 1'b1, 32'h200);
    look("same_old", 32'h140, 1'b0, 32'h144);
    tick(); idle();
    look("same_new", 32'h140, 1'b1, 32'h200);
    cnts("same", 10, 8);

    // 5b. reset wins over a simultaneous update
    rst = 1'b1;
    upd(32'h40, 1'b1, 32'h300, 32'h44);
    tick();
    rst = 1'b0; idle();
    look("rst_upd_40", 32'h40, 1'b0, 32'h44);
    look("rst_upd_140", 32'h140, 1'b0, 32'h144);
    cnts("rst_upd", 0, 0);

    // 6. counter saturation at 15 with CNT_W=4
    for (int i = 0; i < 20; i++) begin
      upd(32'h80, 1'b1, 32'h400, 32'h0);
      #1;
      chk($sformatf("sat%0d.mispredict", i), 32'(mispredict), 32'd1);
      tick(); idle();
      cnts($sformatf("sat%0d", i), (i + 1 > 15) ? 15 : i + 1, (i + 1 > 15) ? 15 : i + 1);
      $display("saturate step %0d branch_cnt=%0d mispred_cnt=%0d", i, branch_cnt, mispred_cnt);
    end

    // no update: counters hold at saturation
    tick();
    cnts("sat_hold", 15, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
